// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BCNT_W         = 2;
  localparam int unsigned HDR_W          = 16;

  // Loader sequencing states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } loader_state_e;

  // States in which the loader consumes stream bytes
  function automatic logic state_accepts(input loader_state_e s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

  // States in which a start request launches a new load
  function automatic logic state_restartable(input loader_state_e s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
  endfunction

endpackage

// File: rtl/byte_to_word_packer.sv
// Packs an MSB-first byte stream into 32-bit words; pulses o_word_valid one
// cycle after the fourth byte of each word.
module byte_to_word_packer
  import imem_loader_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clear,
  input  logic              i_byte_en,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_valid,
  output logic              o_last_byte_c
);

  localparam int unsigned SHIFT_W = WORD_W - BYTE_W;

  logic [BCNT_W-1:0]  r_cnt;
  logic [SHIFT_W-1:0] r_shift;
  logic [WORD_W-1:0]  r_word;
  logic               r_word_valid;

  // Fourth byte of the current word is being accepted this cycle
  assign o_last_byte_c = i_byte_en && (r_cnt == BCNT_W'(BYTES_PER_WORD - 1));

  // Shift register, byte counter and registered word strobe
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt        <= '0;
      r_shift      <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= o_last_byte_c;
      if (i_clear) begin
        r_cnt   <= '0;
        r_shift <= '0;
      end else if (i_byte_en) begin
        r_cnt   <= r_cnt + BCNT_W'(1);
        r_shift <= {r_shift[SHIFT_W-BYTE_W-1:0], i_byte};
        if (o_last_byte_c) begin
          r_word <= {r_shift, i_byte};
        end
      end
    end
  end

  assign o_word       = r_word;
  assign o_word_valid = r_word_valid;

endmodule

// File: rtl/imem_program_loader.sv
// Boot-time loader: parses a length header, big-endian words and an XOR
// checksum from a byte stream, writes imem and holds the core until verified.
module imem_program_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [DATA_W-1:0] o_imem_wdata,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_error,
  output logic [ADDR_W:0]   o_words_loaded
);

  localparam int unsigned CNT_W     = ADDR_W + 1;
  localparam int unsigned MAX_WORDS = 32'(1) << ADDR_W;

  loader_state_e     r_state, w_state_nxt;
  logic [BYTE_W-1:0] r_len_hi, w_len_hi_nxt;
  logic [CNT_W-1:0]  r_len, w_len_nxt;
  logic [BYTE_W-1:0] r_csum, w_csum_nxt;
  logic [CNT_W-1:0]  r_words, w_words_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic              r_rx_ready, w_rx_ready_nxt;
  logic              r_cpu_hold, w_cpu_hold_nxt;
  logic              r_done, w_done_nxt;
  logic              r_error, w_error_nxt;

  logic              w_accept;
  logic              w_clear;
  logic              w_data_en;
  logic              w_last_byte;
  logic              w_word_valid;
  logic [WORD_W-1:0] w_word;
  logic [HDR_W-1:0]  w_len_full;

  assign w_accept   = i_rx_valid && r_rx_ready;
  assign w_data_en  = w_accept && (r_state == ST_DATA);
  assign w_len_full = {r_len_hi, i_rx_data};

  byte_to_word_packer u_packer (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_clear       (w_clear),
    .i_byte_en     (w_data_en),
    .i_byte        (i_rx_data),
    .o_word        (w_word),
    .o_word_valid  (w_word_valid),
    .o_last_byte_c (w_last_byte)
  );

  // Next-state, datapath and registered-output decode
  always_comb begin
    w_state_nxt  = r_state;
    w_len_hi_nxt = r_len_hi;
    w_len_nxt    = r_len;
    w_csum_nxt   = r_csum;
    w_words_nxt  = r_words;
    w_addr_nxt   = r_addr;
    w_clear      = 1'b0;

    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (i_start) begin
          w_state_nxt = ST_LEN_HI;
          w_clear     = 1'b1;
          w_csum_nxt  = '0;
          w_words_nxt = '0;
        end
      end
      ST_LEN_HI: begin
        if (w_accept) begin
          w_len_hi_nxt = i_rx_data;
          w_csum_nxt   = r_csum ^ i_rx_data;
          w_state_nxt  = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (w_accept) begin
          w_csum_nxt = r_csum ^ i_rx_data;
          if (32'(w_len_full) > MAX_WORDS) begin
            w_state_nxt = ST_ERROR;
          end else if (w_len_full == '0) begin
            w_state_nxt = ST_CSUM;
          end else begin
            w_len_nxt   = CNT_W'(w_len_full);
            w_state_nxt = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_accept) begin
          w_csum_nxt = r_csum ^ i_rx_data;
          if (w_last_byte) begin
            // Address and count update alongside the packer's write strobe
            w_addr_nxt  = r_words[ADDR_W-1:0];
            w_words_nxt = r_words + CNT_W'(1);
            if (w_words_nxt == r_len) begin
              w_state_nxt = ST_CSUM;
            end
          end
        end
      end
      ST_CSUM: begin
        if (w_accept) begin
          w_state_nxt = (i_rx_data == r_csum) ? ST_DONE : ST_ERROR;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Status outputs follow the state being entered, so they are coherent
    // with it and done/error can never overlap.
    w_rx_ready_nxt = state_accepts(w_state_nxt);
    w_done_nxt     = (w_state_nxt == ST_DONE);
    w_error_nxt    = (w_state_nxt == ST_ERROR);
    w_cpu_hold_nxt = (w_state_nxt != ST_DONE);
  end

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= ST_IDLE;
      r_len_hi   <= '0;
      r_len      <= '0;
      r_csum     <= '0;
      r_words    <= '0;
      r_addr     <= '0;
      r_rx_ready <= 1'b0;
      r_cpu_hold <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_len_hi   <= w_len_hi_nxt;
      r_len      <= w_len_nxt;
      r_csum     <= w_csum_nxt;
      r_words    <= w_words_nxt;
      r_addr     <= w_addr_nxt;
      r_rx_ready <= w_rx_ready_nxt;
      r_cpu_hold <= w_cpu_hold_nxt;
      r_done     <= w_done_nxt;
      r_error    <= w_error_nxt;
    end
  end

  assign o_rx_ready     = r_rx_ready;
  assign o_imem_we      = w_word_valid;
  assign o_imem_addr    = r_addr;
  assign o_imem_wdata   = DATA_W'(w_word);
  assign o_cpu_hold     = r_cpu_hold;
  assign o_done         = r_done;
  assign o_error        = r_error;
  assign o_words_loaded = r_words;

endmodule

// File: tb/tb_imem_program_loader.sv
// Self-checking bench for imem_program_loader: directed and random images
// checked against a stream-level model of the image format.
module tb_imem_program_loader;

  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned DATA_W    = 32;
  localparam int          MAX_WORDS = 1 << ADDR_W;

  typedef logic [7:0] byte_t;
  typedef byte_t byte_q_t [$];

  logic              i_clk;
  logic              i_reset;
  logic              i_start;
  logic [7:0]        i_rx_data;
  logic              i_rx_valid;
  logic              o_rx_ready;
  logic              o_imem_we;
  logic [ADDR_W-1:0] o_imem_addr;
  logic [DATA_W-1:0] o_imem_wdata;
  logic              o_cpu_hold;
  logic              o_done;
  logic              o_error;
  logic [ADDR_W:0]   o_words_loaded;

  imem_program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_start        (i_start),
    .i_rx_data      (i_rx_data),
    .i_rx_valid     (i_rx_valid),
    .o_rx_ready     (o_rx_ready),
    .o_imem_we      (o_imem_we),
    .o_imem_addr    (o_imem_addr),
    .o_imem_wdata   (o_imem_wdata),
    .o_cpu_hold     (o_cpu_hold),
    .o_done         (o_done),
    .o_error        (o_error),
    .o_words_loaded (o_words_loaded)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Every imem write observed, as {addr, data}
  logic [ADDR_W+DATA_W-1:0] got_q [$];
  // Stream position tracking for the write-timing expectation
  int cur_len;
  int acc_idx;
  bit pend_we;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: per-cycle checks at the falling edge, then return just after the rising edge
  task automatic cycle();
    bit acc;
    @(negedge i_clk);
    chk("we_timing", 64'(o_imem_we), 64'(pend_we));
    chk("done_error_exclusive", 64'(o_done & o_error), 64'(0));
    if (o_imem_we === 1'b1) got_q.push_back({o_imem_addr, o_imem_wdata});
    acc = (i_rx_valid === 1'b1) && (o_rx_ready === 1'b1);
    pend_we = 1'b0;
    if (acc) begin
      if (acc_idx >= 2 && acc_idx < 2 + 4 * cur_len && ((acc_idx - 2) % 4) == 3) pend_we = 1'b1;
      acc_idx++;
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input byte_t b);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    chk("rx_ready_busy", 64'(o_rx_ready), 64'(1));
    chk("cpu_hold_busy", 64'(o_cpu_hold), 64'(1));
    chk("done_busy", 64'(o_done), 64'(0));
    cycle();
    i_rx_valid = 1'b0;
  endtask

  task automatic gap(input int n, input bit pulses);
    for (int g = 0; g < n; g++) begin
      i_start = pulses ? 1'($urandom_range(0, 1)) : 1'b0;
      cycle();
    end
    i_start = 1'b0;
  endtask

  // Start a load, stream an image and compare against the format model
  task automatic run_load(input string tag, input byte_q_t bs, input int gmin, input int gmax,
                          input bit pulses);
    int    len, n_send, base, n_exp, n_got;
    bit    over, ok;
    byte_t x;
    len    = int'({bs[0], bs[1]});
    over   = len > MAX_WORDS;
    n_send = over ? 2 : 2 + 4 * len + 1;
    if (bs.size() < n_send) begin
      $display("FAIL %s: stimulus shorter than header implies", tag);
      $fatal(1, "bad stimulus");
    end
    x = 8'h00;
    for (int i = 0; i < n_send - 1; i++) x = x ^ bs[i];
    ok    = !over && (bs[n_send-1] == x);
    n_exp = over ? 0 : len;

    base    = got_q.size();
    cur_len = over ? 0 : len;
    acc_idx = 0;
    i_start = 1'b1;
    cycle();
    i_start = 1'b0;
    chk({tag, "/start_hold"}, 64'(o_cpu_hold), 64'(1));
    chk({tag, "/start_ready"}, 64'(o_rx_ready), 64'(1));
    chk({tag, "/start_flags"}, 64'({o_done, o_error}), 64'(0));
    chk({tag, "/start_words"}, 64'(o_words_loaded), 64'(0));

    for (int i = 0; i < n_send; i++) begin
      send_byte(bs[i]);
      if (i != n_send - 1) gap($urandom_range(gmin, gmax), pulses);
    end

    chk({tag, "/done"}, 64'(o_done), 64'(ok));
    chk({tag, "/error"}, 64'(o_error), 64'(!ok));
    chk({tag, "/cpu_hold"}, 64'(o_cpu_hold), 64'(!ok));
    chk({tag, "/rx_ready_end"}, 64'(o_rx_ready), 64'(0));
    chk({tag, "/words_loaded"}, 64'(o_words_loaded), 64'(n_exp));
    n_got = got_q.size() - base;
    chk({tag, "/write_count"}, 64'(n_got), 64'(n_exp));
    for (int i = 0; i < n_exp && i < n_got; i++) begin
      chk($sformatf("%s/write%0d", tag, i), 64'(got_q[base+i]),
          64'({ADDR_W'(i), bs[2+4*i], bs[3+4*i], bs[4+4*i], bs[5+4*i]}));
    end
    cycle();
    chk({tag, "/done_hold"}, 64'(o_done), 64'(ok));
  endtask

  function automatic byte_q_t make_img(input int len, input bit bad);
    byte_q_t q;
    byte_t   x;
    logic [15:0] l16;
    l16 = 16'(len);
    q.push_back(l16[15:8]);
    q.push_back(l16[7:0]);
    if (len > MAX_WORDS) return q;
    for (int i = 0; i < 4 * len; i++) q.push_back(8'($urandom));
    x = 8'h00;
    foreach (q[i]) x = x ^ q[i];
    if (bad) x = x ^ 8'($urandom_range(1, 255));
    q.push_back(x);
    return q;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    byte_q_t t1, t2, t3, t4, img;
    int base;
    t1 = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h0A, 8'h20, 8'h02, 8'h00, 8'h14, 8'h1F};
    t2 = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h0A, 8'h20, 8'h02, 8'h00, 8'h14, 8'h1E};
    t3 = '{8'h00, 8'h00, 8'h00};
    t4 = '{8'h04, 8'h01};
    cur_len    = 0;
    acc_idx    = 0;
    pend_we    = 1'b0;
    i_start    = 1'b0;
    i_rx_data  = 8'h00;
    i_rx_valid = 1'b0;
    i_reset    = 1'b1;
    #3 i_reset = 1'b0;
    #1;
    chk("reset_outputs", 64'({o_rx_ready, o_imem_we, o_cpu_hold, o_done, o_error}), 64'(5'b00100));
    chk("reset_addr", 64'(o_imem_addr), 64'(0));
    chk("reset_wdata", 64'(o_imem_wdata), 64'(0));
    chk("reset_words", 64'(o_words_loaded), 64'(0));
    cycle();
    cycle();
    i_reset = 1'b1;
    cycle();
    chk("idle_hold", 64'({o_cpu_hold, o_rx_ready}), 64'(2'b10));

    run_load("t1_basic", t1, 0, 0, 1'b0);
    run_load("t2_badcsum", t2, 0, 0, 1'b0);
    run_load("t2_reload", t1, 0, 0, 1'b0);
    run_load("t3_zero_len", t3, 0, 1, 1'b0);
    run_load("t4_overlength", t4, 0, 0, 1'b0);
    run_load("t5_gaps_start", t1, 3, 3, 1'b1);

    // Reset in the middle of the data phase
    base    = got_q.size();
    cur_len = 2;
    acc_idx = 0;
    i_start = 1'b1;
    cycle();
    i_start = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(t1[i]);
    #2 i_reset = 1'b0;
    #1;
    chk("t6_async_outputs", 64'({o_rx_ready, o_imem_we, o_cpu_hold, o_done, o_error}), 64'(5'b00100));
    chk("t6_async_addr", 64'(o_imem_addr), 64'(0));
    chk("t6_async_wdata", 64'(o_imem_wdata), 64'(0));
    chk("t6_async_words", 64'(o_words_loaded), 64'(0));
    cycle();
    chk("t6_partial_count", 64'(got_q.size() - base), 64'(1));
    if (got_q.size() > base) chk("t6_partial_write", 64'(got_q[base]), 64'({ADDR_W'(0), 32'h2001000A}));
    i_reset = 1'b1;
    cycle();
    chk("t6_idle_after", 64'({o_cpu_hold, o_rx_ready, o_done}), 64'(3'b100));
    run_load("t6_reload", t1, 0, 0, 1'b0);

    // Boundary: the largest legal image fills imem exactly
    img = make_img(MAX_WORDS, 1'b0);
    run_load("max_len", img, 0, 0, 1'b0);
    img = make_img(MAX_WORDS + 1, 1'b0);
    run_load("max_plus_one", img, 0, 0, 1'b0);

    for (int k = 0; k < 10; k++) begin
      int len;
      bit bad;
      len = $urandom_range(0, 6);
      bad = ($urandom_range(0, 2) == 0);
      if (k == 7) len = MAX_WORDS + 1 + $urandom_range(0, 60000);
      img = make_img(len, bad);
      run_load($sformatf("rand%0d", k), img, 0, 2, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
